// File: rtl/lut_table_loader.sv
// Runtime-programmable LUT neuron: streams a truth table into a shadow copy,
// commits it atomically to the active table, and serves registered lookups.
module lut_table_loader #(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                lut_valid_in,
  input  logic [IN_BITS-1:0]  lut_in,
  output logic                lut_valid_out,
  output logic [OUT_BITS-1:0] lut_out
);
  localparam int DEPTH = 1 << IN_BITS;
  localparam int CW    = IN_BITS + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMMIT} state_t;

  state_t                         r_state, w_state_nxt;
  logic [CW-1:0]                  r_cnt, w_cnt_nxt;
  logic [DEPTH-1:0][OUT_BITS-1:0] r_shadow, r_active;
  logic                           w_accept, w_wr, w_err_nxt, w_commit;
  logic                           r_done, r_err, r_loaded, r_lut_vld;
  logic [OUT_BITS-1:0]            r_lut_out;

  assign cfg_ready = !rst && (r_state != S_COMMIT);
  assign w_accept  = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr        = 1'b0;
    w_err_nxt   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_wr = 1'b1;
          if (cfg_last) begin
            // a one-beat table is always malformed; cnt stays 0 so IDLE always writes entry 0
            w_err_nxt = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_wr      = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (cfg_last) begin
            if (r_cnt == LAST_IDX) begin
              w_state_nxt = S_COMMIT;
            end else begin
              w_err_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end
          end else if (r_cnt == LAST_IDX) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_accept && cfg_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lookups read the pre-edge active table, so a COMMIT-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_loaded  <= 1'b0;
      r_lut_vld <= 1'b0;
      r_lut_out <= '0;
    end else begin
      if (w_wr) r_shadow[r_cnt[IN_BITS-1:0]] <= cfg_data;
      if (w_commit) begin
        r_active <= r_shadow;
        r_loaded <= 1'b1;
      end
      r_done    <= w_commit;
      r_err     <= w_err_nxt;
      r_lut_vld <= lut_valid_in;
      if (lut_valid_in) r_lut_out <= r_active[lut_in];
    end
  end

  assign cfg_done      = r_done;
  assign cfg_err       = r_err;
  assign loaded        = r_loaded;
  assign lut_valid_out = r_lut_vld;
  assign lut_out       = r_lut_out;
endmodule

// File: tb/tb_lut_table_loader.sv
// Directed + randomized bench for lut_table_loader; the reference model classifies
// each config frame by its length and only tracks the committed table contents.
module tb_lut_table_loader;
  localparam int IN_BITS  = 4;
  localparam int OUT_BITS = 2;
  localparam int DEPTH    = 1 << IN_BITS;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data = '0;
  logic                cfg_last = 1'b0;
  logic                cfg_done, cfg_err, loaded;
  logic                lut_valid_in = 1'b0;
  logic [IN_BITS-1:0]  lut_in = '0;
  logic                lut_valid_out;
  logic [OUT_BITS-1:0] lut_out;

  int checks   = 0;
  int failures = 0;

  logic [OUT_BITS-1:0] ref_active [DEPTH];
  logic                ref_loaded;
  logic [OUT_BITS-1:0] frame [64];

  lut_table_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .loaded(loaded),
    .lut_valid_in(lut_valid_in), .lut_in(lut_in),
    .lut_valid_out(lut_valid_out), .lut_out(lut_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_frame(input int len);
    for (int i = 0; i < len; i++) frame[i] = OUT_BITS'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; lut_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_lut_vld", lut_valid_out, 0);
    chk("rst_lut_out", lut_out, 0);
    rst = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_active[i] = '0;
    ref_loaded = 1'b0;
  endtask

  task automatic lookup(input int addr);
    @(negedge clk);
    lut_valid_in = 1'b1; lut_in = IN_BITS'(addr);
    @(posedge clk); #1;
    chk("lut_vld", lut_valid_out, 1);
    chk("lut_out", lut_out, ref_active[addr]);
    @(negedge clk);
    lut_valid_in = 1'b0; lut_in = IN_BITS'($urandom);
    @(posedge clk); #1;
    chk("lut_vld_low", lut_valid_out, 0);
    chk("lut_hold", lut_out, ref_active[addr]);
  endtask

  // Frame model: exactly DEPTH beats commits; shorter frames error on their last beat;
  // longer frames error on beat DEPTH and the remainder is dropped.
  task automatic run_frame(input int len, input bit gaps, input int abort_at, input bit collide);
    int idx = 0;
    int cyc = 0;
    int err_at;
    bit v, rdy;
    logic [OUT_BITS-1:0] old;
    err_at = (len < DEPTH) ? len - 1 : ((len > DEPTH) ? DEPTH - 1 : -1);
    while (idx < len) begin
      if (abort_at > 0 && idx == abort_at) return;
      if (cyc >= 2000) begin
        checks++; failures++;
        $error("FAIL frame_timeout: observed=%0d beats expected=%0d beats", idx, len);
        return;
      end
      @(negedge clk);
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_valid = v; cfg_data = frame[idx]; cfg_last = (idx == len - 1);
      rdy = cfg_ready;
      chk("ready_in_frame", rdy, 1);
      @(posedge clk); #1;
      chk("err_beat", cfg_err, (v && rdy && idx == err_at) ? 1 : 0);
      chk("done_beat", cfg_done, 0);
      if (v && rdy) idx++;
      cyc++;
    end
    @(negedge clk);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    if (len == DEPTH) begin
      chk("ready_commit", cfg_ready, 0);
      old = ref_active[10];
      if (collide) begin lut_valid_in = 1'b1; lut_in = IN_BITS'(10); end
      @(posedge clk); #1;
      chk("done_pulse", cfg_done, 1);
      chk("err_at_commit", cfg_err, 0);
      chk("loaded_set", loaded, 1);
      for (int i = 0; i < DEPTH; i++) ref_active[i] = frame[i];
      ref_loaded = 1'b1;
      if (collide) chk("collide_old", lut_out, old);
      @(negedge clk);
      chk("ready_after_commit", cfg_ready, 1);
      @(posedge clk); #1;
      chk("done_clear", cfg_done, 0);
      if (collide) begin
        chk("collide_new", lut_out, ref_active[10]);
        @(negedge clk);
        lut_valid_in = 1'b0;
      end
    end else begin
      @(posedge clk); #1;
      chk("err_clear", cfg_err, 0);
      chk("no_done", cfg_done, 0);
      chk("loaded_kept", loaded, ref_loaded);
    end
  endtask

  initial begin
    int len;
    for (int i = 0; i < DEPTH; i++) ref_active[i] = '0;
    ref_loaded = 1'b0;
    rst = 1'b1; cfg_valid = 1'b1;
    apply_reset();

    // 1: lookup before any commit
    lookup(10);
    chk("loaded_initial", loaded, 0);

    // 2: directed back-to-back load
    for (int i = 0; i < DEPTH; i++) frame[i] = '0;
    frame[2] = 2'b01; frame[8] = 2'b10; frame[10] = 2'b11;
    run_frame(DEPTH, 1'b0, 0, 1'b0);
    lookup(8); lookup(2); lookup(10); lookup(5);

    // 3: early last on beat 6, then an immediate new load is accepted
    rand_frame(7);
    run_frame(7, 1'b0, 0, 1'b0);
    lookup(10);
    chk("early_last_tbl", ref_active[10], 2'b11);

    // 4: missing last, 19 beats with last on the 19th
    rand_frame(19);
    run_frame(19, 1'b0, 0, 1'b0);
    lookup(10); lookup(2);

    // 5: commit/lookup collision on entry 10
    for (int i = 0; i < DEPTH; i++) frame[i] = ref_active[i];
    frame[10] = 2'b00;
    run_frame(DEPTH, 1'b0, 0, 1'b1);

    // 6: reset after 9 beats of a gappy load, then a full gappy load
    rand_frame(DEPTH);
    run_frame(DEPTH, 1'b1, 9, 1'b0);
    apply_reset();
    lookup(10); lookup(8);
    chk("loaded_after_rst", loaded, 0);
    rand_frame(DEPTH);
    run_frame(DEPTH, 1'b1, 0, 1'b0);
    for (int a = 0; a < DEPTH; a++) lookup(a);

    // randomized frames: mostly well-formed, some short or overlong
    for (int n = 0; n < 8; n++) begin
      len = ($urandom_range(0, 1) == 0) ? DEPTH : int'($urandom_range(1, DEPTH + 4));
      rand_frame(len);
      run_frame(len, 1'($urandom_range(0, 1)), 0, 1'b0);
      for (int k = 0; k < 3; k++) lookup(int'($urandom_range(0, DEPTH - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
